// File: rtl/uart_tx_fifo.sv
// 8N1 serial transmitter with a small byte FIFO in front of it.
// Bytes are sent LSB first; queued frames go out back-to-back with no idle gap.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_valid,
    input  logic [7:0] wr_byte,
    output logic       wr_ready,
    output logic       overflow,
    output logic       busy,
    output logic       tx
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              overflow_q;

    state_t            state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic              tx_q;
    logic              busy_q;

    logic full;
    logic push;
    logic baud_last;
    logic frame_end;
    logic pop;
    logic idle_next;

    // A full FIFO never accepts, even if a pop happens at the same edge.
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign push      = wr_valid && !full;
    assign baud_last = (baud_q == BAUD_LAST);
    // The line is free for a new frame when idle or at the last stop-bit cycle.
    assign frame_end = (state_q == S_IDLE) || ((state_q == S_STOP) && baud_last);
    assign pop       = frame_end && (count_q != '0);
    assign idle_next = frame_end && (count_q == '0);

    // Occupancy after this edge; push and pop together leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // FIFO storage; stale entries are harmless because the pointers reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_byte;
        end
    end

    // FIFO pointers, occupancy and the overflow pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q    <= count_d;
            overflow_q <= wr_valid && full;
        end
    end

    // Frame sequencer with registered line and busy outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            busy_q <= !idle_next || (count_d != '0);
            case (state_q)
                S_IDLE: begin
                    tx_q   <= 1'b1;
                    baud_q <= '0;
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        state_q <= S_START;
                        tx_q    <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        state_q   <= S_DATA;
                        tx_q      <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q <= mem_q[rd_ptr_q];
                            state_q <= S_START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign wr_ready = !full;
    assign overflow = overflow_q;
    assign busy     = busy_q;
    assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int LOGN  = 8192;

    logic       clk;
    logic       reset_n;
    logic       wr_valid;
    logic [7:0] wr_byte;
    logic       wr_ready;
    logic       overflow;
    logic       busy;
    logic       tx;

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_valid(wr_valid),
        .wr_byte (wr_byte),
        .wr_ready(wr_ready),
        .overflow(overflow),
        .busy    (busy),
        .tx      (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Frame-level reference: queue of waiting bytes, byte on the line and
    // the number of cycles elapsed since its start bit began.
    logic [7:0] mq[$];
    logic       m_active = 1'b0;
    int         m_t = 0;
    logic [7:0] m_cur = 8'h00;
    logic       m_ovf = 1'b0;

    int   cyc = 0;
    logic tx_log [LOGN];
    logic rdy_log[LOGN];
    int   ovf_cnt = 0;

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [7:0] data;
        logic       tx;
        logic       busy;
        logic       ready;
        logic       ovf;
    } vec_t;

    vec_t tbl[8];

    task automatic chk_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0b expected=%0b", name, cyc, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
        end
    endtask

    function automatic logic model_tx();
        if (!m_active)          return 1'b1;
        if (m_t < CPB)          return 1'b0;
        if (m_t < 9 * CPB)      return m_cur[(m_t - CPB) / CPB];
        return 1'b1;
    endfunction

    task automatic model_edge(input logic r, input logic v, input logic [7:0] b);
        bit frame_done;
        if (!r) begin
            mq.delete();
            m_active = 1'b0;
            m_t      = 0;
            m_ovf    = 1'b0;
        end else begin
            m_ovf      = v && (mq.size() == DEPTH);
            frame_done = !m_active || (m_t == 10 * CPB - 1);
            if (frame_done && mq.size() > 0) begin
                m_cur    = mq.pop_front();
                m_active = 1'b1;
                m_t      = 0;
            end else if (frame_done) begin
                m_active = 1'b0;
            end else begin
                m_t++;
            end
            if (v && !m_ovf) mq.push_back(b);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
    task automatic step(input logic r, input logic v, input logic [7:0] b);
        reset_n  = r;
        wr_valid = v;
        wr_byte  = b;
        @(posedge clk);
        model_edge(r, v, b);
        #1;
        cyc++;
        if (cyc < LOGN) begin
            tx_log[cyc]  = tx;
            rdy_log[cyc] = wr_ready;
        end
        if (overflow === 1'b1) ovf_cnt++;
        chk_bit("model_tx", tx, model_tx());
        chk_bit("model_busy", busy, m_active || (mq.size() != 0));
        chk_bit("model_wr_ready", wr_ready, mq.size() < DEPTH);
        chk_bit("model_overflow", overflow, m_ovf);
    endtask

    // Decodes the frame whose start bit begins at log index base (mid-bit samples).
    task automatic check_frame(input string name, input int base, input int exp_byte);
        int got;
        got = 0;
        for (int b = 0; b < 10; b++) begin
            if (tx_log[base + b * CPB + CPB / 2] === 1'b1) got = got | (1 << b);
        end
        chk_int(name, got, (1 << 9) | ((exp_byte & 8'hFF) << 1));
    endtask

    initial begin
        int   base;
        int   lowcnt;
        int   busycnt;
        int   rdylow;
        logic [9:0] pat;
        logic [7:0] fb;
        logic [7:0] wb[5];
        int   pos;
        logic expb;

        // rst, valid, data | tx, busy, ready, ovf
        tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 8'h06, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};

        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_byte  = 8'h00;

        // Reset, then 100 idle cycles.
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk_bit("reset_tx", tx, 1'b1);
        chk_bit("reset_busy", busy, 1'b0);
        chk_bit("reset_wr_ready", wr_ready, 1'b1);
        chk_bit("reset_overflow", overflow, 1'b0);
        lowcnt = 0; busycnt = 0; rdylow = 0; ovf_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0, 8'h00);
            if (tx !== 1'b1) lowcnt++;
            if (busy !== 1'b0) busycnt++;
            if (wr_ready !== 1'b1) rdylow++;
        end
        chk_int("idle_tx_low", lowcnt, 0);
        chk_int("idle_busy", busycnt, 0);
        chk_int("idle_not_ready", rdylow, 0);
        chk_int("idle_overflow", ovf_cnt, 0);

        // Single 0xA5 frame from idle.
        step(1'b1, 1'b1, 8'hA5);
        chk_bit("a5_e0_tx", tx, 1'b1);
        chk_bit("a5_e0_busy", busy, 1'b1);
        pat  = {1'b1, 8'hA5, 1'b0};
        base = cyc + 1;
        for (int k = 0; k < 10 * CPB; k++) begin
            step(1'b1, 1'b0, 8'h00);
            chk_bit("a5_line", tx, pat[k / CPB]);
            chk_bit("a5_busy", busy, 1'b1);
        end
        step(1'b1, 1'b0, 8'h00);
        chk_bit("a5_busy_fall", busy, 1'b0);
        chk_bit("a5_tx_idle", tx, 1'b1);
        check_frame("a5_decode", base, 8'hA5);

        // Six-byte burst into a four-deep FIFO.
        ovf_cnt = 0;
        base = 0;
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].rst_n, tbl[i].valid, tbl[i].data);
            if (i == 2) base = cyc;
            chk_bit("tbl_tx", tx, tbl[i].tx);
            chk_bit("tbl_busy", busy, tbl[i].busy);
            chk_bit("tbl_wr_ready", wr_ready, tbl[i].ready);
            chk_bit("tbl_overflow", overflow, tbl[i].ovf);
        end
        while (cyc < base + 205) step(1'b1, 1'b0, 8'h00);
        for (int f = 0; f < 5; f++) check_frame("burst_frame", base + f * 10 * CPB, f + 1);
        chk_bit("burst_ready_before_pop2", rdy_log[base + 10 * CPB - 1], 1'b0);
        chk_bit("burst_ready_after_pop2", rdy_log[base + 10 * CPB], 1'b1);
        chk_int("burst_overflow_pulses", ovf_cnt, 1);
        chk_bit("burst_done_busy", busy, 1'b0);

        // 0x00 then 0xFF back-to-back, bit-exact.
        step(1'b1, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'hFF);
        base = cyc;
        for (int k = 1; k < 20 * CPB; k++) step(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 20 * CPB; k++) begin
            fb  = (k < 10 * CPB) ? 8'h00 : 8'hFF;
            pos = (k % (10 * CPB)) / CPB;
            if (pos == 0)      expb = 1'b0;
            else if (pos == 9) expb = 1'b1;
            else               expb = fb[pos - 1];
            chk_bit("b2b_line", tx_log[base + k], expb);
        end
        step(1'b1, 1'b0, 8'h00);
        chk_bit("b2b_busy_fall", busy, 1'b0);

        // Reset in the middle of DATA for 0x3C with two bytes queued.
        step(1'b1, 1'b1, 8'h3C);
        step(1'b1, 1'b1, 8'h11);
        step(1'b1, 1'b1, 8'h22);
        for (int k = 2; k < 15; k++) step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk_bit("midrst_tx", tx, 1'b1);
        chk_bit("midrst_busy", busy, 1'b0);
        chk_bit("midrst_wr_ready", wr_ready, 1'b1);
        lowcnt = 0; busycnt = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0, 8'h00);
            if (tx !== 1'b1) lowcnt++;
            if (busy !== 1'b0) busycnt++;
        end
        chk_int("midrst_no_frames", lowcnt, 0);
        chk_int("midrst_stays_idle", busycnt, 0);

        // Push at the same edge as a pop with three entries queued; pointers wrap.
        wb[0] = 8'h5A; wb[1] = 8'hC3; wb[2] = 8'h81; wb[3] = 8'h7E; wb[4] = 8'h99;
        step(1'b0, 1'b0, 8'h00);
        rdylow = 0;
        step(1'b1, 1'b1, wb[0]);
        step(1'b1, 1'b1, wb[1]);
        base = cyc;
        step(1'b1, 1'b1, wb[2]);
        step(1'b1, 1'b1, wb[3]);
        while (cyc < base + 10 * CPB - 1) begin
            step(1'b1, 1'b0, 8'h00);
            if (wr_ready !== 1'b1) rdylow++;
        end
        step(1'b1, 1'b1, wb[4]);
        if (wr_ready !== 1'b1) rdylow++;
        while (cyc < base + 205) begin
            step(1'b1, 1'b0, 8'h00);
            if (wr_ready !== 1'b1) rdylow++;
        end
        chk_int("wrap_count_held", rdylow, 0);
        for (int f = 0; f < 5; f++) check_frame("wrap_order", base + f * 10 * CPB, int'(wb[f]));

        // Random traffic against the reference model.
        step(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 699) != 0), ($urandom_range(0, 3) == 0),
                 8'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, ($urandom_range(0, 59) == 0), 8'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
